cpu_ctrl_fsm: RTL and testbench
===============================

// Module: cpu_ctrl_fsm
// PURPOSE
//   Multi-cycle control unit for the 19-bit CPU: sequences fetch/decode/execute/memory/writeback.
//   Drives instruction register load_IR, PC update, register-file write, ALU op and memory handshake
//   from IR opcode and datapath status. Sits between inst_reg, regfile/ALU, PC and memory port.
// PARAMETERS
//   OPC_W       5    opcode width (IR bits [18:14])
//   ALU_OP_W    4    ALU operation select width
//   MEM_TIMEOUT 255  max mem_ready wait cycles before fault; 0 disables timeout
//   PERF_W      32   perf counter width (CTRL_PERF_CNT_EN only)
// PORTS
//   clk          in   1         system clock, all state on posedge
//   rst          in   1         synchronous active-high reset
//   opcode       in   OPC_W     decoded opcode from inst_reg (valid from DECODE onward)
//   alu_zero     in   1         ALU result==0 (compare of rs1,rs2)
//   alu_busy     in   1         ALU multi-cycle op (MUL/DIV) in progress
//   mem_ready    in   1         memory completes current request this cycle
//   load_IR      out  1         capture mem read data into inst_reg
//   pc_inc       out  1         PC <= PC+1
//   pc_branch    out  1         PC <= PC+1+sign-extended branch_offset
//   pc_load      out  1         PC <= addr_imm
//   alu_op       out  ALU_OP_W  ALU function select
//   alu_start    out  1         one-cycle ALU launch pulse
//   rf_we        out  1         register file write enable (dest rd, or rs2 for LD)
//   wb_sel       out  2         writeback source: 0 ALU, 1 MEM, 2 PC+1
//   mem_req      out  1         memory request, held until mem_ready
//   mem_we       out  1         1 write, 0 read (qualified by mem_req)
//   addr_sel     out  2         memory address: 0 PC, 1 ALU result, 2 SP
//   sp_dec       out  1         decrement stack pointer (CALL push)
//   halted       out  1         sticky: illegal opcode or memory timeout
//   fault_code   out  2         0 none, 1 illegal opcode, 2 mem timeout
//   state_dbg    out  3         current state encoding
// BEHAVIOUR
//   States: FETCH, DECODE, EXEC, MEM, WB, HALT. Strobe outputs combinational from state/inputs.
//   Reset: state<=FETCH, halted=0, fault_code=0, timer=0; all strobes forced 0 while rst=1.
//   FETCH: mem_req=1, mem_we=0, addr_sel=0; on mem_ready: load_IR=1 -> DECODE; else stay.
//   DECODE: opcode 0-9 -> EXEC; 10,11 (LD/ST) -> EXEC; 12,13 (BEQ/BNE) -> EXEC;
//     14 JMP: pc_load=1 -> FETCH; 15 CALL -> MEM; 16-31: fault_code=1 -> HALT.
//   EXEC entry cycle: alu_start=1. alu_op = opcode[3:0] for ALU class, 0 (ADD) for LD/ST, 1 (SUB) for BEQ/BNE.
//     Stay in EXEC while alu_busy=1 (alu_start only on entry cycle).
//     ALU class, alu_busy=0: rf_we=1, wb_sel=0, pc_inc=1 -> FETCH.
//     LD/ST, alu_busy=0 -> MEM.  BEQ: alu_zero=1 -> pc_branch, else pc_inc; BNE inverse -> FETCH.
//   MEM: mem_req=1; LD: mem_we=0, addr_sel=1; ST: mem_we=1, addr_sel=1; CALL: mem_we=1, addr_sel=2, wb_sel=2.
//     On mem_ready: LD -> WB; ST: pc_inc -> FETCH; CALL: sp_dec=1, pc_load=1 -> FETCH.
//   WB: rf_we=1, wb_sel=1, pc_inc=1 -> FETCH.
//   Exactly one of pc_inc/pc_branch/pc_load per instruction; never two in one cycle.
//   Timeout: timer counts consecutive cycles of mem_req=1 & mem_ready=0, clears on mem_ready or state change;
//     reaching MEM_TIMEOUT (non-zero) -> fault_code=2, HALT; mem_ready same cycle as limit wins (no fault).
//   HALT: all strobes 0, halted=1; exits only on rst.
//   rst mid-operation (any state, incl. mid mem_req): next cycle FETCH, request dropped, no PC/RF update.
// CONFIGURATION
//   CTRL_PERF_CNT_EN defined: adds outputs cyc_cnt, ret_cnt [PERF_W-1:0]; cyc_cnt increments every
//     non-reset, non-HALT cycle; ret_cnt increments on each FETCH-returning transition; both wrap, reset 0.
//   Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//   cpu_pkg: opcode localparams (OPC_ADD..OPC_CALL), state encoding, wb_sel/addr_sel/fault codes.
//   Sub-module ctrl_mem_timer: wait counter + timeout compare (MEM_TIMEOUT param, 0 disables).
// TESTING
//   ADD (op 0), mem_ready on 1st FETCH cycle -> FETCH,DECODE,EXEC; rf_we+pc_inc in EXEC; 3 cycles/instr.
//   DIV (op 3), alu_busy high 5 cycles -> alu_start once, rf_we only on cycle alu_busy=0.
//   LD, mem_ready after 3 wait cycles in MEM -> mem_req held 4 cycles, then WB rf_we=1 wb_sel=1.
//   BEQ alu_zero=1 -> pc_branch=1; BNE alu_zero=1 -> pc_inc=1; CALL -> mem_we=1 addr_sel=2, then sp_dec+pc_load.
//   Opcode 20 -> halted=1 fault_code=1, strobes 0 forever; rst -> FETCH, halted=0.
//   MEM_TIMEOUT=4, mem_ready never -> HALT fault_code=2 after 4 wait cycles; rst mid-FETCH drops mem_req.

Source files
------------

// File: rtl/cpu_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle CPU control FSM: opcodes, states,
// opcode classes, writeback/address selects, fault codes and ALU ops.
package cpu_ctrl_fsm_pkg;

    localparam logic [4:0] OPC_ADD      = 5'd0;
    localparam logic [4:0] OPC_SUB      = 5'd1;
    localparam logic [4:0] OPC_MUL      = 5'd2;
    localparam logic [4:0] OPC_DIV      = 5'd3;
    localparam logic [4:0] OPC_ALU_LAST = 5'd9;
    localparam logic [4:0] OPC_LD       = 5'd10;
    localparam logic [4:0] OPC_ST       = 5'd11;
    localparam logic [4:0] OPC_BEQ      = 5'd12;
    localparam logic [4:0] OPC_BNE      = 5'd13;
    localparam logic [4:0] OPC_JMP      = 5'd14;
    localparam logic [4:0] OPC_CALL     = 5'd15;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU  = 3'd0,
        CLS_LD   = 3'd1,
        CLS_ST   = 3'd2,
        CLS_BEQ  = 3'd3,
        CLS_BNE  = 3'd4,
        CLS_JMP  = 3'd5,
        CLS_CALL = 3'd6,
        CLS_ILL  = 3'd7
    } opc_class_e;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC1 = 2'd2;

    localparam logic [1:0] ADDR_PC  = 2'd0;
    localparam logic [1:0] ADDR_ALU = 2'd1;
    localparam logic [1:0] ADDR_SP  = 2'd2;

    localparam logic [1:0] FAULT_NONE    = 2'd0;
    localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
    localparam logic [1:0] FAULT_TIMEOUT = 2'd2;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;

    // Map an opcode onto the instruction class that drives sequencing.
    function automatic opc_class_e opc_class(input logic [4:0] opc);
        opc_class_e c;
        case (opc)
            OPC_LD:   c = CLS_LD;
            OPC_ST:   c = CLS_ST;
            OPC_BEQ:  c = CLS_BEQ;
            OPC_BNE:  c = CLS_BNE;
            OPC_JMP:  c = CLS_JMP;
            OPC_CALL: c = CLS_CALL;
            default:  c = (opc <= OPC_ALU_LAST) ? CLS_ALU : CLS_ILL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_mem_timer.sv
// Memory wait counter: counts consecutive cycles of an outstanding request
// without mem_ready and flags a timeout on the cycle the limit is reached.
// MEM_TIMEOUT = 0 disables the timeout entirely.
module cpu_ctrl_fsm_mem_timer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_req,
    input  logic mem_ready,
    output logic timeout
);

    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    logic [TW-1:0] timer_r;

    // Count unanswered request cycles; any answered or idle cycle restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_r <= '0;
        end else if (mem_req && !mem_ready && (MEM_TIMEOUT != 0)) begin
            timer_r <= timer_r + TW'(1);
        end else begin
            timer_r <= '0;
        end
    end

    // Flag the limit cycle; a mem_ready arriving in that same cycle wins.
    always_comb begin
        if (MEM_TIMEOUT != 0) begin
            timeout = mem_req && !mem_ready && (timer_r == TW'(MEM_TIMEOUT - 1));
        end else begin
            timeout = 1'b0;
        end
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control unit for the 19-bit CPU. Sequences FETCH, DECODE,
// EXEC, MEM and WB, and parks in HALT on an illegal opcode or memory timeout.
// Strobes are combinational from the registered state; halted, fault_code
// and state_dbg are registered. Optional build macro CTRL_PERF_CNT_EN adds
// the cyc_cnt / ret_cnt performance counters.
module cpu_ctrl_fsm
    import cpu_ctrl_fsm_pkg::*;
#(
    parameter int OPC_W       = 5,
    parameter int ALU_OP_W    = 4,
`ifdef CTRL_PERF_CNT_EN
    parameter int PERF_W      = 32,
`endif
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPC_W-1:0]    opcode,
    input  logic                alu_zero,
    input  logic                alu_busy,
    input  logic                mem_ready,
    output logic                load_IR,
    output logic                pc_inc,
    output logic                pc_branch,
    output logic                pc_load,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                alu_start,
    output logic                rf_we,
    output logic [1:0]          wb_sel,
    output logic                mem_req,
    output logic                mem_we,
    output logic [1:0]          addr_sel,
    output logic                sp_dec,
    output logic                halted,
    output logic [1:0]          fault_code,
    output logic [2:0]          state_dbg
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]   cyc_cnt,
    output logic [PERF_W-1:0]   ret_cnt
`endif
);

    state_e     state_r;
    state_e     next_s;
    logic       halted_r;
    logic [1:0] fault_code_r;
    logic [1:0] fault_s;
    logic       exec_entry_r;
    logic       mem_req_s;
    logic       timeout_s;
    opc_class_e cls_s;

    assign cls_s      = opc_class(opcode);
    assign mem_req    = mem_req_s;
    assign halted     = halted_r;
    assign fault_code = fault_code_r;
    assign state_dbg  = state_r;

    // Memory request is a pure function of state so the timer sees no loop.
    always_comb begin
        if (rst) begin
            mem_req_s = 1'b0;
        end else begin
            mem_req_s = (state_r == ST_FETCH) || (state_r == ST_MEM);
        end
    end

    cpu_ctrl_fsm_mem_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req_s),
        .mem_ready (mem_ready),
        .timeout   (timeout_s)
    );

    // Next-state and strobe decode; every strobe is held low during reset.
    always_comb begin
        next_s    = state_r;
        fault_s   = FAULT_NONE;
        load_IR   = 1'b0;
        pc_inc    = 1'b0;
        pc_branch = 1'b0;
        pc_load   = 1'b0;
        alu_op    = '0;
        alu_start = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = WB_ALU;
        mem_we    = 1'b0;
        addr_sel  = ADDR_PC;
        sp_dec    = 1'b0;
        if (rst) begin
            next_s = ST_FETCH;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (mem_ready) begin
                        load_IR = 1'b1;
                        next_s  = ST_DECODE;
                    end else if (timeout_s) begin
                        fault_s = FAULT_TIMEOUT;
                        next_s  = ST_HALT;
                    end else begin
                        next_s = ST_FETCH;
                    end
                end
                ST_DECODE: begin
                    case (cls_s)
                        CLS_JMP: begin
                            pc_load = 1'b1;
                            next_s  = ST_FETCH;
                        end
                        CLS_CALL: next_s = ST_MEM;
                        CLS_ILL: begin
                            fault_s = FAULT_ILLEGAL;
                            next_s  = ST_HALT;
                        end
                        default:  next_s = ST_EXEC;
                    endcase
                end
                ST_EXEC: begin
                    alu_start = exec_entry_r;
                    case (cls_s)
                        CLS_LD, CLS_ST:   alu_op = ALU_OP_W'(ALU_ADD);
                        CLS_BEQ, CLS_BNE: alu_op = ALU_OP_W'(ALU_SUB);
                        default:          alu_op = ALU_OP_W'(opcode[3:0]);
                    endcase
                    if (alu_busy) begin
                        next_s = ST_EXEC;
                    end else begin
                        case (cls_s)
                            CLS_LD, CLS_ST: next_s = ST_MEM;
                            CLS_BEQ: begin
                                pc_branch = alu_zero;
                                pc_inc    = !alu_zero;
                                next_s    = ST_FETCH;
                            end
                            CLS_BNE: begin
                                pc_branch = !alu_zero;
                                pc_inc    = alu_zero;
                                next_s    = ST_FETCH;
                            end
                            default: begin
                                rf_we  = 1'b1;
                                wb_sel = WB_ALU;
                                pc_inc = 1'b1;
                                next_s = ST_FETCH;
                            end
                        endcase
                    end
                end
                ST_MEM: begin
                    case (cls_s)
                        CLS_ST: begin
                            mem_we   = 1'b1;
                            addr_sel = ADDR_ALU;
                        end
                        CLS_CALL: begin
                            mem_we   = 1'b1;
                            addr_sel = ADDR_SP;
                            wb_sel   = WB_PC1;
                        end
                        default: begin
                            mem_we   = 1'b0;
                            addr_sel = ADDR_ALU;
                        end
                    endcase
                    if (mem_ready) begin
                        case (cls_s)
                            CLS_LD: next_s = ST_WB;
                            CLS_CALL: begin
                                sp_dec  = 1'b1;
                                pc_load = 1'b1;
                                next_s  = ST_FETCH;
                            end
                            default: begin
                                pc_inc = 1'b1;
                                next_s = ST_FETCH;
                            end
                        endcase
                    end else if (timeout_s) begin
                        fault_s = FAULT_TIMEOUT;
                        next_s  = ST_HALT;
                    end else begin
                        next_s = ST_MEM;
                    end
                end
                ST_WB: begin
                    rf_we  = 1'b1;
                    wb_sel = WB_MEM;
                    pc_inc = 1'b1;
                    next_s = ST_FETCH;
                end
                ST_HALT: next_s = ST_HALT;
                default: next_s = ST_FETCH;
            endcase
        end
    end

    // State register plus sticky halt/fault capture and EXEC entry marker.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_FETCH;
            halted_r     <= 1'b0;
            fault_code_r <= FAULT_NONE;
            exec_entry_r <= 1'b0;
        end else begin
            state_r      <= next_s;
            exec_entry_r <= (state_r == ST_DECODE) && (next_s == ST_EXEC);
            if (fault_s != FAULT_NONE) begin
                halted_r     <= 1'b1;
                fault_code_r <= fault_s;
            end else begin
                halted_r     <= halted_r;
                fault_code_r <= fault_code_r;
            end
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [PERF_W-1:0] cyc_cnt_r;
    logic [PERF_W-1:0] ret_cnt_r;

    assign cyc_cnt = cyc_cnt_r;
    assign ret_cnt = ret_cnt_r;

    // Active-cycle and retired-instruction counters, both free-running wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt_r <= '0;
            ret_cnt_r <= '0;
        end else begin
            if (state_r != ST_HALT) begin
                cyc_cnt_r <= cyc_cnt_r + PERF_W'(1);
            end else begin
                cyc_cnt_r <= cyc_cnt_r;
            end
            if ((next_s == ST_FETCH) && (state_r != ST_FETCH)) begin
                ret_cnt_r <= ret_cnt_r + PERF_W'(1);
            end else begin
                ret_cnt_r <= ret_cnt_r;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm (MEM_TIMEOUT = 4). Each scenario
// queues per-cycle stimulus with the expected outputs; the cycle loop pops
// and compares once the DUT outputs have settled mid-cycle.
module tb_cpu_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] opcode;
    logic       alu_zero, alu_busy, mem_ready;
    logic       load_IR, pc_inc, pc_branch, pc_load, alu_start, rf_we;
    logic       mem_req, mem_we, sp_dec, halted;
    logic [3:0] alu_op;
    logic [1:0] wb_sel, addr_sel, fault_code;
    logic [2:0] state_dbg;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cyc_cnt, ret_cnt;
`endif

    cpu_ctrl_fsm #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .alu_zero(alu_zero),
        .alu_busy(alu_busy), .mem_ready(mem_ready), .load_IR(load_IR),
        .pc_inc(pc_inc), .pc_branch(pc_branch), .pc_load(pc_load),
        .alu_op(alu_op), .alu_start(alu_start), .rf_we(rf_we),
        .wb_sel(wb_sel), .mem_req(mem_req), .mem_we(mem_we),
        .addr_sel(addr_sel), .sp_dec(sp_dec), .halted(halted),
        .fault_code(fault_code), .state_dbg(state_dbg)
`ifdef CTRL_PERF_CNT_EN
        , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
    );

    always #5 clk = ~clk;

    // stb bit order: load_IR pc_inc pc_branch pc_load alu_start rf_we mem_req mem_we sp_dec halted
    typedef struct packed {
        logic [2:0] st;
        logic [9:0] stb;
        logic [3:0] aop;
        logic [1:0] wb;
        logic [1:0] as;
        logic [1:0] fc;
    } obs_t;

    typedef struct packed {
        logic [4:0] opc;
        logic       r;
        logic       rdy;
        logic       busy;
        logic       zero;
    } stim_t;

    localparam logic [2:0] F = 3'd0, D = 3'd1, X = 3'd2, M = 3'd3, W = 3'd4, H = 3'd5;
    localparam logic [9:0] NONE    = 10'b0000000000;
    localparam logic [9:0] REQ     = 10'b0000001000;
    localparam logic [9:0] FLOAD   = 10'b1000001000;
    localparam logic [9:0] START   = 10'b0000100000;
    localparam logic [9:0] ALU_WR  = 10'b0100110000;
    localparam logic [9:0] WR_INC  = 10'b0100010000;
    localparam logic [9:0] WREQ    = 10'b0000001100;
    localparam logic [9:0] ST_DONE = 10'b0100001100;
    localparam logic [9:0] BR      = 10'b0010100000;
    localparam logic [9:0] INC_ST  = 10'b0100100000;
    localparam logic [9:0] JMPL    = 10'b0001000000;
    localparam logic [9:0] CALLD   = 10'b0001001110;
    localparam logic [9:0] HLT     = 10'b0000000001;

    stim_t st_q[$];
    obs_t  sb[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    function automatic stim_t S(logic [4:0] opc, logic r, logic rdy, logic busy, logic zero);
        return '{opc: opc, r: r, rdy: rdy, busy: busy, zero: zero};
    endfunction

    function automatic obs_t E(logic [2:0] st, logic [9:0] stb, logic [3:0] aop,
                               logic [1:0] wb, logic [1:0] as, logic [1:0] fc);
        return '{st: st, stb: stb, aop: aop, wb: wb, as: as, fc: fc};
    endfunction

    function automatic void add(stim_t s, obs_t e);
        st_q.push_back(s);
        sb.push_back(e);
    endfunction

    function automatic obs_t obs_now();
        return '{st: state_dbg,
                 stb: {load_IR, pc_inc, pc_branch, pc_load, alu_start, rf_we,
                       mem_req, mem_we, sp_dec, halted},
                 aop: alu_op, wb: wb_sel, as: addr_sel, fc: fault_code};
    endfunction

    task automatic apply(stim_t s);
        @(negedge clk);
        opcode = s.opc; rst = s.r; mem_ready = s.rdy; alu_busy = s.busy; alu_zero = s.zero;
        #1;
    endtask

    // One plain ALU instruction opcode = opc, three cycles
    function automatic void queue_alu(logic [4:0] opc);
        add(S(opc, 1'b0, 1'b1, 1'b0, 1'b0), E(F, FLOAD,  4'd0,     2'd0, 2'd0, 2'd0));
        add(S(opc, 1'b0, 1'b0, 1'b0, 1'b0), E(D, NONE,   4'd0,     2'd0, 2'd0, 2'd0));
        add(S(opc, 1'b0, 1'b0, 1'b0, 1'b0), E(X, ALU_WR, opc[3:0], 2'd0, 2'd0, 2'd0));
    endfunction

    task automatic test_reset();
        obs_t e, g;
        add(S(5'd0, 1'b1, 1'b1, 1'b1, 1'b1), E(F, NONE, 4'd0, 2'd0, 2'd0, 2'd0));
        add(S(5'd0, 1'b0, 1'b0, 1'b0, 1'b0), E(F, REQ,  4'd0, 2'd0, 2'd0, 2'd0));
        add(S(5'd0, 1'b1, 1'b1, 1'b0, 1'b0), E(F, NONE, 4'd0, 2'd0, 2'd0, 2'd0));
        add(S(5'd0, 1'b0, 1'b0, 1'b0, 1'b0), E(F, REQ,  4'd0, 2'd0, 2'd0, 2'd0));
        for (int i = 0; st_q.size() > 0; i++) begin
            apply(st_q.pop_front());
            g = obs_now(); e = sb.pop_front(); n_tests++;
            if (g !== e) begin n_fail++; $display("FAIL reset[%0d]: got %h expected %h", i, g, e); end
        end
    endtask

    task automatic test_add();
        obs_t e, g;
        queue_alu(5'd0);
        for (int i = 0; st_q.size() > 0; i++) begin
            apply(st_q.pop_front());
            g = obs_now(); e = sb.pop_front(); n_tests++;
            if (g !== e) begin n_fail++; $display("FAIL add[%0d]: got %h expected %h", i, g, e); end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, g;
        queue_alu(5'd7);
        queue_alu(5'd9);
        queue_alu(5'd1);
        for (int i = 0; st_q.size() > 0; i++) begin
            apply(st_q.pop_front());
            g = obs_now(); e = sb.pop_front(); n_tests++;
            if (g !== e) begin n_fail++; $display("FAIL b2b[%0d]: got %h expected %h", i, g, e); end
        end
    endtask

    task automatic test_div();
        obs_t e, g;
        add(S(5'd3, 1'b0, 1'b1, 1'b0, 1'b0), E(F, FLOAD, 4'd0, 2'd0, 2'd0, 2'd0));
        add(S(5'd3, 1'b0, 1'b0, 1'b0, 1'b0), E(D, NONE,  4'd0, 2'd0, 2'd0, 2'd0));
        add(S(5'd3, 1'b0, 1'b0, 1'b1, 1'b0), E(X, START, 4'd3, 2'd0, 2'd0, 2'd0));
        for (int k = 0; k < 4; k++)
            add(S(5'd3, 1'b0, 1'b0, 1'b1, 1'b0), E(X, NONE, 4'd3, 2'd0, 2'd0, 2'd0));
        add(S(5'd3, 1'b0, 1'b0, 1'b0, 1'b0), E(X, WR_INC, 4'd3, 2'd0, 2'd0, 2'd0));
        for (int i = 0; st_q.size() > 0; i++) begin
            apply(st_q.pop_front());
            g = obs_now(); e = sb.pop_front(); n_tests++;
            if (g !== e) begin n_fail++; $display("FAIL div[%0d]: got %h expected %h", i, g, e); end
        end
    endtask

    task automatic test_ld();
        obs_t e, g;
        add(S(5'd10, 1'b0, 1'b1, 1'b0, 1'b0), E(F, FLOAD, 4'd0, 2'd0, 2'd0, 2'd0));
        add(S(5'd10, 1'b0, 1'b0, 1'b0, 1'b0), E(D, NONE,  4'd0, 2'd0, 2'd0, 2'd0));
        add(S(5'd10, 1'b0, 1'b0, 1'b0, 1'b0), E(X, START, 4'd0, 2'd0, 2'd0, 2'd0));
        for (int k = 0; k < 3; k++)
            add(S(5'd10, 1'b0, 1'b0, 1'b0, 1'b0), E(M, REQ, 4'd0, 2'd0, 2'd1, 2'd0));
        add(S(5'd10, 1'b0, 1'b1, 1'b0, 1'b0), E(M, REQ,    4'd0, 2'd0, 2'd1, 2'd0));
        add(S(5'd10, 1'b0, 1'b0, 1'b0, 1'b0), E(W, WR_INC, 4'd0, 2'd1, 2'd0, 2'd0));
        for (int i = 0; st_q.size() > 0; i++) begin
            apply(st_q.pop_front());
            g = obs_now(); e = sb.pop_front(); n_tests++;
            if (g !== e) begin n_fail++; $display("FAIL ld[%0d]: got %h expected %h", i, g, e); end
        end
    endtask

    task automatic test_st();
        obs_t e, g;
        add(S(5'd11, 1'b0, 1'b1, 1'b0, 1'b0), E(F, FLOAD,   4'd0, 2'd0, 2'd0, 2'd0));
        add(S(5'd11, 1'b0, 1'b0, 1'b0, 1'b0), E(D, NONE,    4'd0, 2'd0, 2'd0, 2'd0));
        add(S(5'd11, 1'b0, 1'b0, 1'b0, 1'b0), E(X, START,   4'd0, 2'd0, 2'd0, 2'd0));
        add(S(5'd11, 1'b0, 1'b1, 1'b0, 1'b0), E(M, ST_DONE, 4'd0, 2'd0, 2'd1, 2'd0));
        for (int i = 0; st_q.size() > 0; i++) begin
            apply(st_q.pop_front());
            g = obs_now(); e = sb.pop_front(); n_tests++;
            if (g !== e) begin n_fail++; $display("FAIL st[%0d]: got %h expected %h", i, g, e); end
        end
    endtask

    task automatic test_branch();
        obs_t e, g;
        // BEQ z=1, BEQ z=0, BNE z=1, BNE z=0
        for (int k = 0; k < 4; k++) begin
            logic [4:0] opc = (k < 2) ? 5'd12 : 5'd13;
            logic       z   = (k % 2 == 0);
            logic [9:0] x   = ((k == 0) || (k == 3)) ? BR : INC_ST;
            add(S(opc, 1'b0, 1'b1, 1'b0, z), E(F, FLOAD, 4'd0, 2'd0, 2'd0, 2'd0));
            add(S(opc, 1'b0, 1'b0, 1'b0, z), E(D, NONE,  4'd0, 2'd0, 2'd0, 2'd0));
            add(S(opc, 1'b0, 1'b0, 1'b0, z), E(X, x,     4'd1, 2'd0, 2'd0, 2'd0));
        end
        for (int i = 0; st_q.size() > 0; i++) begin
            apply(st_q.pop_front());
            g = obs_now(); e = sb.pop_front(); n_tests++;
            if (g !== e) begin n_fail++; $display("FAIL branch[%0d]: got %h expected %h", i, g, e); end
        end
    endtask

    task automatic test_jmp_call();
        obs_t e, g;
        add(S(5'd14, 1'b0, 1'b1, 1'b0, 1'b0), E(F, FLOAD, 4'd0, 2'd0, 2'd0, 2'd0));
        add(S(5'd14, 1'b0, 1'b0, 1'b0, 1'b0), E(D, JMPL,  4'd0, 2'd0, 2'd0, 2'd0));
        add(S(5'd15, 1'b0, 1'b1, 1'b0, 1'b0), E(F, FLOAD, 4'd0, 2'd0, 2'd0, 2'd0));
        add(S(5'd15, 1'b0, 1'b0, 1'b0, 1'b0), E(D, NONE,  4'd0, 2'd0, 2'd0, 2'd0));
        add(S(5'd15, 1'b0, 1'b0, 1'b0, 1'b0), E(M, WREQ,  4'd0, 2'd2, 2'd2, 2'd0));
        add(S(5'd15, 1'b0, 1'b1, 1'b0, 1'b0), E(M, CALLD, 4'd0, 2'd2, 2'd2, 2'd0));
        add(S(5'd0,  1'b0, 1'b0, 1'b0, 1'b0), E(F, REQ,   4'd0, 2'd0, 2'd0, 2'd0));
        for (int i = 0; st_q.size() > 0; i++) begin
            apply(st_q.pop_front());
            g = obs_now(); e = sb.pop_front(); n_tests++;
            if (g !== e) begin n_fail++; $display("FAIL jmp_call[%0d]: got %h expected %h", i, g, e); end
        end
    endtask

    task automatic test_rst_mid();
        obs_t e, g;
        add(S(5'd11, 1'b0, 1'b1, 1'b0, 1'b0), E(F, FLOAD, 4'd0, 2'd0, 2'd0, 2'd0));
        add(S(5'd11, 1'b0, 1'b0, 1'b0, 1'b0), E(D, NONE,  4'd0, 2'd0, 2'd0, 2'd0));
        add(S(5'd11, 1'b0, 1'b0, 1'b0, 1'b0), E(X, START, 4'd0, 2'd0, 2'd0, 2'd0));
        add(S(5'd11, 1'b0, 1'b0, 1'b0, 1'b0), E(M, WREQ,  4'd0, 2'd0, 2'd1, 2'd0));
        add(S(5'd11, 1'b1, 1'b1, 1'b0, 1'b0), E(M, NONE,  4'd0, 2'd0, 2'd0, 2'd0));
        add(S(5'd11, 1'b0, 1'b0, 1'b0, 1'b0), E(F, REQ,   4'd0, 2'd0, 2'd0, 2'd0));
        for (int i = 0; st_q.size() > 0; i++) begin
            apply(st_q.pop_front());
            g = obs_now(); e = sb.pop_front(); n_tests++;
            if (g !== e) begin n_fail++; $display("FAIL rst_mid[%0d]: got %h expected %h", i, g, e); end
        end
    endtask

    task automatic test_illegal();
        obs_t e, g;
        for (int k = 0; k < 2; k++) begin
            logic [4:0] opc = (k == 0) ? 5'd20 : 5'd16;
            add(S(opc, 1'b0, 1'b1, 1'b0, 1'b0), E(F, FLOAD, 4'd0, 2'd0, 2'd0, 2'd0));
            add(S(opc, 1'b0, 1'b0, 1'b0, 1'b0), E(D, NONE,  4'd0, 2'd0, 2'd0, 2'd0));
            for (int j = 0; j < 3; j++)
                add(S(opc, 1'b0, 1'b1, 1'b1, 1'b1), E(H, HLT, 4'd0, 2'd0, 2'd0, 2'd1));
            add(S(opc, 1'b1, 1'b1, 1'b0, 1'b0), E(H, HLT, 4'd0, 2'd0, 2'd0, 2'd1));
            add(S(opc, 1'b0, 1'b0, 1'b0, 1'b0), E(F, REQ, 4'd0, 2'd0, 2'd0, 2'd0));
        end
        for (int i = 0; st_q.size() > 0; i++) begin
            apply(st_q.pop_front());
            g = obs_now(); e = sb.pop_front(); n_tests++;
            if (g !== e) begin n_fail++; $display("FAIL illegal[%0d]: got %h expected %h", i, g, e); end
        end
    endtask

    task automatic test_timeout();
        obs_t e, g;
        // ST: mem_ready on the limit cycle completes normally
        add(S(5'd11, 1'b0, 1'b1, 1'b0, 1'b0), E(F, FLOAD, 4'd0, 2'd0, 2'd0, 2'd0));
        add(S(5'd11, 1'b0, 1'b0, 1'b0, 1'b0), E(D, NONE,  4'd0, 2'd0, 2'd0, 2'd0));
        add(S(5'd11, 1'b0, 1'b0, 1'b0, 1'b0), E(X, START, 4'd0, 2'd0, 2'd0, 2'd0));
        for (int k = 0; k < 3; k++)
            add(S(5'd11, 1'b0, 1'b0, 1'b0, 1'b0), E(M, WREQ, 4'd0, 2'd0, 2'd1, 2'd0));
        add(S(5'd11, 1'b0, 1'b1, 1'b0, 1'b0), E(M, ST_DONE, 4'd0, 2'd0, 2'd1, 2'd0));
        // LD: four unanswered MEM cycles -> HALT with timeout fault
        add(S(5'd10, 1'b0, 1'b1, 1'b0, 1'b0), E(F, FLOAD, 4'd0, 2'd0, 2'd0, 2'd0));
        add(S(5'd10, 1'b0, 1'b0, 1'b0, 1'b0), E(D, NONE,  4'd0, 2'd0, 2'd0, 2'd0));
        add(S(5'd10, 1'b0, 1'b0, 1'b0, 1'b0), E(X, START, 4'd0, 2'd0, 2'd0, 2'd0));
        for (int k = 0; k < 4; k++)
            add(S(5'd10, 1'b0, 1'b0, 1'b0, 1'b0), E(M, REQ, 4'd0, 2'd0, 2'd1, 2'd0));
        for (int k = 0; k < 2; k++)
            add(S(5'd10, 1'b0, 1'b1, 1'b0, 1'b0), E(H, HLT, 4'd0, 2'd0, 2'd0, 2'd2));
        add(S(5'd10, 1'b1, 1'b0, 1'b0, 1'b0), E(H, HLT, 4'd0, 2'd0, 2'd0, 2'd2));
        // FETCH: four unanswered cycles -> HALT with timeout fault
        for (int k = 0; k < 4; k++)
            add(S(5'd0, 1'b0, 1'b0, 1'b0, 1'b0), E(F, REQ, 4'd0, 2'd0, 2'd0, 2'd0));
        add(S(5'd0, 1'b0, 1'b0, 1'b0, 1'b0), E(H, HLT,  4'd0, 2'd0, 2'd0, 2'd2));
        add(S(5'd0, 1'b1, 1'b0, 1'b0, 1'b0), E(H, HLT,  4'd0, 2'd0, 2'd0, 2'd2));
        add(S(5'd0, 1'b0, 1'b0, 1'b0, 1'b0), E(F, REQ,  4'd0, 2'd0, 2'd0, 2'd0));
        for (int i = 0; st_q.size() > 0; i++) begin
            apply(st_q.pop_front());
            g = obs_now(); e = sb.pop_front(); n_tests++;
            if (g !== e) begin n_fail++; $display("FAIL timeout[%0d]: got %h expected %h", i, g, e); end
        end
    endtask

    // Hard stop in case the run ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scenario sequence.
    initial begin
        rst = 1'b1; opcode = 5'd0; alu_zero = 1'b0; alu_busy = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_add();
        test_back_to_back();
        test_div();
        test_ld();
        test_st();
        test_branch();
        test_jmp_call();
        test_rst_mid();
        test_illegal();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
